ibutterfly_pipe: RTL and testbench



---
 rtl/ibutterfly_pipe_pkg.sv | 13 +
 rtl/ibutterfly_pipe_if.sv | 34 +++
 rtl/ibutterfly_pipe_round_sat.sv | 40 ++++
 rtl/ibutterfly_pipe.sv | 107 ++++++++++
 tb/tb_ibutterfly_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibutterfly_pipe_pkg.sv
// Shared FFT datapath definitions: default lane width, sample type,
// saturation bounds and frame length used by the butterfly blocks.
package ibutterfly_pipe_pkg;

    localparam int unsigned FFT_WIDTH     = 16;
    localparam int unsigned FFT_FRAME_LEN = 8;

    typedef logic signed [FFT_WIDTH-1:0] sample_t;

    localparam sample_t SAT_MAX = {1'b0, {(FFT_WIDTH-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(FFT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/ibutterfly_pipe_if.sv
// Streaming bus of the inverse butterfly: input pair, output pair, framing
// and saturation status. The block itself sits on the slave modport.
interface ibutterfly_pipe_if
    import ibutterfly_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] a_re;
    logic signed [WIDTH-1:0] a_im;
    logic signed [WIDTH-1:0] b_re;
    logic signed [WIDTH-1:0] b_im;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] x1_re;
    logic signed [WIDTH-1:0] x1_im;
    logic signed [WIDTH-1:0] x2_re;
    logic signed [WIDTH-1:0] x2_im;
    logic                    frame_last;
    logic                    sat_clear;
    logic                    sat_flag;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, out_ready, sat_clear,
        input  in_ready, out_valid, x1_re, x1_im, x2_re, x2_im, frame_last, sat_flag
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, out_ready, sat_clear,
        output in_ready, out_valid, x1_re, x1_im, x2_re, x2_im, frame_last, sat_flag
    );

endinterface

// File: rtl/ibutterfly_pipe_round_sat.sv
// Per-lane halve (round-half-up) or pass-through, then clamp from WIDTH+1
// bits to the signed WIDTH-bit range, flagging when the clamp engages.
module ibf_round_sat #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SCALE = 1
) (
    input  logic signed [WIDTH:0]   v_i,
    output logic signed [WIDTH-1:0] r_o,
    output logic                    sat_o
);
    // Two guard bits: v+1 can reach 2^WIDTH before the shift.
    localparam logic signed [WIDTH+1:0] MAX_W = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] MIN_W = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH+1:0] ONE_W = {{(WIDTH+1){1'b0}}, 1'b1};

    logic signed [WIDTH+1:0] v_x;
    logic signed [WIDTH+1:0] r_w;
    logic                    hi;
    logic                    lo;

    always_comb begin
        v_x = {v_i[WIDTH], v_i};
        if (SCALE != 0) begin
            r_w = (v_x + ONE_W) >>> 1;
        end else begin
            r_w = v_x;
        end
        hi    = r_w > MAX_W;
        lo    = r_w < MIN_W;
        sat_o = hi || lo;
        if (hi) begin
            r_o = MAX_W[WIDTH-1:0];
        end else if (lo) begin
            r_o = MIN_W[WIDTH-1:0];
        end else begin
            r_o = r_w[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ibutterfly_pipe.sv
// Two-stage pipelined radix-2 inverse butterfly: S1 forms sum/difference,
// S2 rounds/saturates into the output registers; frame counter and sticky sat flag.
module ibutterfly_pipe
    import ibutterfly_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = FFT_WIDTH,
    parameter int unsigned SCALE     = 1,
    parameter int unsigned FRAME_LEN = FFT_FRAME_LEN
) (
    input logic              clock,
    input logic              reset,
    ibutterfly_pipe_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic                         v1_q, v1_d;
    logic                         v2_q, v2_d;
    logic [3:0][WIDTH:0]          st_q, st_d;
    logic [3:0][WIDTH-1:0]        x_q, x_d;
    logic [3:0][WIDTH-1:0]        r;
    logic [3:0]                   lane_sat;
    logic                         sat_q, sat_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         load1, load2, accept, s2_fire, xfer;
    logic signed [WIDTH:0]        a_re_x, a_im_x, b_re_x, b_im_x;

    always_comb begin
        a_re_x = {bus.a_re[WIDTH-1], bus.a_re};
        a_im_x = {bus.a_im[WIDTH-1], bus.a_im};
        b_re_x = {bus.b_re[WIDTH-1], bus.b_re};
        b_im_x = {bus.b_im[WIDTH-1], bus.b_im};
    end

    // Lane order matches the output order: x1_re, x1_im, x2_re, x2_im.
    always_comb begin
        load2   = !v2_q || bus.out_ready;
        load1   = !v1_q || load2;
        accept  = bus.in_valid && load1;
        s2_fire = load2 && v1_q;
        xfer    = v2_q && bus.out_ready;

        v1_d = load1 ? bus.in_valid : v1_q;
        st_d = st_q;
        if (accept) begin
            st_d[0] = a_re_x + b_re_x;
            st_d[1] = a_im_x + b_im_x;
            st_d[2] = a_re_x - b_re_x;
            st_d[3] = a_im_x - b_im_x;
        end

        v2_d = load2 ? v1_q : v2_q;
        x_d  = s2_fire ? r : x_q;

        sat_d = sat_q;
        if (bus.sat_clear) begin
            sat_d = 1'b0;
        end else if (s2_fire && (|lane_sat)) begin
            sat_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (xfer) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        ibf_round_sat #(
            .WIDTH (WIDTH),
            .SCALE (SCALE)
        ) u_round_sat (
            .v_i   (st_q[i]),
            .r_o   (r[i]),
            .sat_o (lane_sat[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            st_q  <= '0;
            x_q   <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            st_q  <= st_d;
            x_q   <= x_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    // out_valid is masked during reset so no transfer can complete that cycle.
    assign bus.in_ready   = load1;
    assign bus.out_valid  = v2_q && !reset;
    assign bus.x1_re      = x_q[0];
    assign bus.x1_im      = x_q[1];
    assign bus.x2_re      = x_q[2];
    assign bus.x2_im      = x_q[3];
    assign bus.frame_last = bus.out_valid && (cnt_q == LAST_CNT);
    assign bus.sat_flag   = sat_q;

endmodule

// File: tb/tb_ibutterfly_pipe.sv
// Self-checking bench for ibutterfly_pipe: directed spec vectors plus a
// scoreboard monitor that checks every output transfer, hold stability and framing.
module tb_ibutterfly_pipe;
    import ibutterfly_pipe_pkg::*;

    localparam int W  = 16;
    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibutterfly_pipe_if #(.WIDTH(W)) if1 ();
    ibutterfly_pipe_if #(.WIDTH(W)) if0 ();

    ibutterfly_pipe #(.WIDTH(W), .SCALE(1), .FRAME_LEN(FL)) dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (if1)
    );

    ibutterfly_pipe #(.WIDTH(W), .SCALE(0), .FRAME_LEN(FL)) dut0 (
        .clock (clk),
        .reset (rst),
        .bus   (if0)
    );

    typedef struct {
        int x1re;
        int x1im;
        int x2re;
        int x2im;
    } exp_t;

    exp_t sb[$];
    int   last_idx[$];
    int   checks = 0;
    int   errors = 0;
    int   out_since_rst = 0;
    int   total_out = 0;

    function automatic int model(input int v, input bit scale);
        int r;
        r = scale ? ((v + 1) >>> 1) : v;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Scoreboard monitor on the SCALE=1 instance, sampling on the falling edge.
    exp_t e;
    exp_t held;
    logic held_last;
    bit   stall_q = 1'b0;
    int   ar, ai, br, bi;
    bit   exp_last;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last_idx.delete();
            out_since_rst = 0;
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (if1.out_valid !== 1'b1 || if1.x1_re !== 16'(held.x1re) || if1.x1_im !== 16'(held.x1im) ||
                    if1.x2_re !== 16'(held.x2re) || if1.x2_im !== 16'(held.x2im) || if1.frame_last !== held_last) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b x1=(%0d,%0d) x2=(%0d,%0d) last=%b, expected v=1 x1=(%0d,%0d) x2=(%0d,%0d) last=%b",
                             if1.out_valid, if1.x1_re, if1.x1_im, if1.x2_re, if1.x2_im, if1.frame_last,
                             held.x1re, held.x1im, held.x2re, held.x2im, held_last);
                end
            end
            if (if1.in_valid === 1'b1 && if1.in_ready === 1'b1) begin
                ar = if1.a_re; ai = if1.a_im; br = if1.b_re; bi = if1.b_im;
                e.x1re = model(ar + br, 1'b1);
                e.x1im = model(ai + bi, 1'b1);
                e.x2re = model(ar - br, 1'b1);
                e.x2im = model(ai - bi, 1'b1);
                sb.push_back(e);
            end
            if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got output x1=(%0d,%0d) x2=(%0d,%0d), expected no output",
                             if1.x1_re, if1.x1_im, if1.x2_re, if1.x2_im);
                end else begin
                    e = sb.pop_front();
                    if (if1.x1_re !== 16'(e.x1re) || if1.x1_im !== 16'(e.x1im) ||
                        if1.x2_re !== 16'(e.x2re) || if1.x2_im !== 16'(e.x2im)) begin
                        errors++;
                        $display("FAIL scoreboard_data: got x1=(%0d,%0d) x2=(%0d,%0d), expected x1=(%0d,%0d) x2=(%0d,%0d)",
                                 if1.x1_re, if1.x1_im, if1.x2_re, if1.x2_im, e.x1re, e.x1im, e.x2re, e.x2im);
                    end
                end
                out_since_rst++;
                total_out++;
                exp_last = (out_since_rst % FL) == 0;
                checks++;
                if (if1.frame_last !== exp_last) begin
                    errors++;
                    $display("FAIL frame_last: output %0d got %b, expected %b", out_since_rst, if1.frame_last, exp_last);
                end
                if (if1.frame_last === 1'b1) last_idx.push_back(out_since_rst);
            end else if (if1.out_valid !== 1'b1) begin
                checks++;
                if (if1.frame_last !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_last_idle: got %b, expected 0", if1.frame_last);
                end
            end
            stall_q = (if1.out_valid === 1'b1) && (if1.out_ready !== 1'b1);
            if (stall_q) begin
                held.x1re = if1.x1_re; held.x1im = if1.x1_im;
                held.x2re = if1.x2_re; held.x2im = if1.x2_im;
                held_last = if1.frame_last;
            end
        end
    end

    task automatic send_pair(input int a_r, input int a_i, input int b_r, input int b_i);
        @(posedge clk); #1;
        if1.a_re = 16'(a_r); if1.a_im = 16'(a_i);
        if1.b_re = 16'(b_r); if1.b_im = 16'(b_i);
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic stream_pairs(input int n);
        bit acc;
        int waitc;
        for (int i = 0; i < n; i++) begin
            if1.a_re = 16'($urandom); if1.a_im = 16'($urandom);
            if1.b_re = 16'($urandom); if1.b_im = 16'($urandom);
            if1.in_valid = 1'b1;
            acc = 1'b0;
            waitc = 0;
            while (!acc && waitc < 50) begin
                @(negedge clk);
                acc = (if1.in_ready === 1'b1);
                @(posedge clk); #1;
                waitc++;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL accept_timeout: pair %0d not accepted within %0d cycles", i, waitc);
            end
        end
        if1.in_valid = 1'b0;
    endtask

    task automatic wait_total(input int target);
        int n;
        n = 0;
        while (total_out < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (total_out != target) begin
            errors++;
            $display("FAIL output_count: got %0d transfers, expected %0d", total_out, target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        if1.in_valid = 1'b0; if1.out_ready = 1'b1; if1.sat_clear = 1'b0;
        if1.a_re = '0; if1.a_im = '0; if1.b_re = '0; if1.b_im = '0;
        if0.in_valid = 1'b0; if0.out_ready = 1'b1; if0.sat_clear = 1'b0;
        if0.a_re = '0; if0.a_im = '0; if0.b_re = '0; if0.b_im = '0;
        do_reset();
        checks++;
        if (if1.out_valid !== 1'b0 || if0.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b/%b, expected 0/0", if1.out_valid, if0.out_valid);
        end
        checks++;
        if (if1.in_ready !== 1'b1 || if0.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b/%b, expected 1/1", if1.in_ready, if0.in_ready);
        end
        checks++;
        if ({if1.x1_re, if1.x1_im, if1.x2_re, if1.x2_im} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got x1=(%0d,%0d) x2=(%0d,%0d), expected zeros",
                               if1.x1_re, if1.x1_im, if1.x2_re, if1.x2_im);
        end
        checks++;
        if (if1.frame_last !== 1'b0 || if1.sat_flag !== 1'b0 || if0.sat_flag !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got last=%b sat=%b/%b, expected 0 0/0",
                               if1.frame_last, if1.sat_flag, if0.sat_flag);
        end
    endtask

    task automatic test_inverse();
        send_pair(300, -40, 100, 20);
        checks++;
        if (if1.out_valid !== 1'b1) begin
            errors++; $display("FAIL inverse_latency: out_valid got %b, expected 1", if1.out_valid);
        end
        checks++;
        if (if1.x1_re !== 16'(200) || if1.x1_im !== 16'(-10) || if1.x2_re !== 16'(100) || if1.x2_im !== 16'(-30)) begin
            errors++; $display("FAIL inverse_data: got x1=(%0d,%0d) x2=(%0d,%0d), expected x1=(200,-10) x2=(100,-30)",
                               if1.x1_re, if1.x1_im, if1.x2_re, if1.x2_im);
        end
        checks++;
        if (if1.sat_flag !== 1'b0) begin
            errors++; $display("FAIL inverse_sat: got %b, expected 0", if1.sat_flag);
        end
    endtask

    task automatic test_rounding();
        send_pair(3, 0, 0, 0);
        checks++;
        if (if1.x1_re !== 16'(2) || if1.x2_re !== 16'(2)) begin
            errors++; $display("FAIL round_pos: got x1_re=%0d x2_re=%0d, expected 2 2", if1.x1_re, if1.x2_re);
        end
        send_pair(-3, 0, 0, 0);
        checks++;
        if (if1.x1_re !== 16'(-1) || if1.x2_re !== 16'(-1)) begin
            errors++; $display("FAIL round_neg: got x1_re=%0d x2_re=%0d, expected -1 -1", if1.x1_re, if1.x2_re);
        end
    endtask

    task automatic test_saturation();
        send_pair(32767, 0, -32768, 0);
        checks++;
        if (if1.x2_re !== 16'(32767) || if1.x1_re !== 16'(0) || if1.sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_scale1: got x1_re=%0d x2_re=%0d sat=%b, expected 0 32767 1",
                               if1.x1_re, if1.x2_re, if1.sat_flag);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (if1.sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_sticky: got %b, expected 1", if1.sat_flag);
        end
        if1.sat_clear = 1'b1;
        @(posedge clk); #1;
        if1.sat_clear = 1'b0;
        checks++;
        if (if1.sat_flag !== 1'b0) begin
            errors++; $display("FAIL sat_clear: got %b, expected 0", if1.sat_flag);
        end
        // Clear coinciding with a saturating S2 load must win.
        if1.a_re = 16'(32767); if1.a_im = '0; if1.b_re = 16'(-32768); if1.b_im = '0;
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        if1.sat_clear = 1'b1;
        @(posedge clk); #1;
        if1.sat_clear = 1'b0;
        checks++;
        if (if1.out_valid !== 1'b1 || if1.x2_re !== 16'(32767) || if1.sat_flag !== 1'b0) begin
            errors++; $display("FAIL sat_clear_priority: got v=%b x2_re=%0d sat=%b, expected 1 32767 0",
                               if1.out_valid, if1.x2_re, if1.sat_flag);
        end
        if0.a_re = 16'(20000); if0.a_im = 16'(-7); if0.b_re = 16'(20000); if0.b_im = 16'(3);
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if0.out_valid !== 1'b1 || if0.x1_re !== 16'(32767) || if0.x2_re !== 16'(0) ||
            if0.x1_im !== 16'(-4) || if0.x2_im !== 16'(-10) || if0.sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_scale0: got v=%b x1=(%0d,%0d) x2=(%0d,%0d) sat=%b, expected 1 x1=(32767,-4) x2=(0,-10) 1",
                               if0.out_valid, if0.x1_re, if0.x1_im, if0.x2_re, if0.x2_im, if0.sat_flag);
        end
    endtask

    task automatic test_backpressure();
        int start;
        int n;
        repeat (3) @(posedge clk);
        #1;
        start = total_out;
        if1.out_ready = 1'b1;
        fork
            stream_pairs(6);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (if1.out_valid !== 1'b1 && n < 50);
                @(posedge clk); #1;
                if1.out_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (if1.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %b, expected 0 with both stages full", if1.in_ready);
                end
                repeat (5) @(posedge clk);
                #1 if1.out_ready = 1'b1;
            end
        join
        wait_total(start + 6);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL bp_leftover: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_framing();
        do_reset();
        if1.out_ready = 1'b1;
        stream_pairs(17);
        wait_total(total_out + 17 - out_since_rst);
        checks++;
        if (last_idx.size() != 2 || last_idx[0] != 8 || last_idx[1] != 16) begin
            errors++; $display("FAIL framing: got %0d frame_last pulses (first %0d), expected 2 at outputs 8 and 16",
                               last_idx.size(), (last_idx.size() > 0) ? last_idx[0] : -1);
        end
    endtask

    task automatic test_reset_midstream();
        int start;
        if1.out_ready = 1'b0;
        if1.a_re = 16'(11); if1.a_im = 16'(22); if1.b_re = 16'(33); if1.b_im = 16'(44);
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.a_re = 16'(-55);
        @(posedge clk); #1;
        checks++;
        if (if1.in_ready !== 1'b0 || if1.out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_full: got in_ready=%b out_valid=%b, expected 0 1", if1.in_ready, if1.out_valid);
        end
        rst = 1'b1;
        if1.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        if1.out_ready = 1'b1;
        checks++;
        if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_after: got out_valid=%b in_ready=%b, expected 0 1", if1.out_valid, if1.in_ready);
        end
        start = total_out;
        stream_pairs(8);
        wait_total(start + 8);
        checks++;
        if (last_idx.size() != 1 || last_idx[0] != 8) begin
            errors++; $display("FAIL midrst_frame: got %0d frame_last pulses (first %0d), expected 1 at output 8",
                               last_idx.size(), (last_idx.size() > 0) ? last_idx[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_inverse();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_framing();
        test_reset_midstream();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
